// File: rtl/md_hazard_if.sv
// Decode/execute-side signal bundle for the multiply/divide hazard controller.
interface md_hazard_if #(
  parameter int unsigned CNT_W = 4
);
  logic [31:0]      IR_D;
  logic [31:0]      IR_E;
  logic             md_busy;
  logic             md_start;
  logic [1:0]       md_kind;
  logic             stall_D;
  logic [CNT_W-1:0] busy_cnt;
  logic             conflict;

  modport master (
    output IR_D, IR_E, md_busy,
    input  md_start, md_kind, stall_D, busy_cnt, conflict
  );

  modport slave (
    input  IR_D, IR_E, md_busy,
    output md_start, md_kind, stall_D, busy_cnt, conflict
  );
endinterface

// File: rtl/md_hazard_ctrl.sv
// Issue/interlock controller for the multiply/divide unit: issues E-stage md ops,
// counts their latency and stalls D-stage HI/LO users until writeback.
module md_hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 5,
  parameter int unsigned CNT_W    = 4
) (
  input logic        clk,
  input logic        rst,
  md_hazard_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] KIND_MULT = 2'd0;
  localparam logic [1:0] KIND_DIV  = 2'd1;
  localparam logic [1:0] KIND_MSUB = 2'd2;
  localparam logic [1:0] KIND_NONE = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             conflict_q, conflict_d;
  logic             md_start_c;
  logic [1:0]       md_kind_c;
  logic             stall_c;

  function automatic logic is_special(input logic [31:0] ir, input logic [5:0] funct);
    return (ir[31:26] == 6'b000000) && (ir[5:0] == funct);
  endfunction

  function automatic logic is_msub(input logic [31:0] ir);
    return (ir[31:26] == 6'b011100) && (ir[5:0] == 6'b000100);
  endfunction

  function automatic logic is_mul(input logic [31:0] ir);
    return is_special(ir, 6'b011000) || is_special(ir, 6'b011001);
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return is_special(ir, 6'b011010) || is_special(ir, 6'b011011);
  endfunction

  function automatic logic is_write(input logic [31:0] ir);
    return is_special(ir, 6'b010001) || is_special(ir, 6'b010011);
  endfunction

  function automatic logic is_read(input logic [31:0] ir);
    return is_special(ir, 6'b010000) || is_special(ir, 6'b010010);
  endfunction

  logic e_start, e_div, e_msub, e_write, d_user;
  logic unused_ir_bits;

  assign e_div   = is_div(bus.IR_E);
  assign e_msub  = is_msub(bus.IR_E);
  assign e_start = is_mul(bus.IR_E) || e_div || e_msub;
  assign e_write = is_write(bus.IR_E);
  assign d_user  = is_mul(bus.IR_D) || is_div(bus.IR_D) || is_msub(bus.IR_D) ||
                   is_write(bus.IR_D) || is_read(bus.IR_D);
  assign unused_ir_bits = ^{bus.IR_D[25:6], bus.IR_E[25:6]};

  // Next-state, counter and issue decode; a new issue always reloads (latest wins).
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    conflict_d = conflict_q;
    md_start_c = 1'b0;
    md_kind_c  = KIND_NONE;

    if (e_start) begin
      md_start_c = 1'b1;
      md_kind_c  = e_msub ? KIND_MSUB : (e_div ? KIND_DIV : KIND_MULT);
    end

    case (state_q)
      IDLE: begin
        if (e_start) begin
          busy_cnt_d = e_div ? DIV_LOAD : MULT_LOAD;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (e_start) begin
          conflict_d = 1'b1;
          busy_cnt_d = e_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          if (e_write) conflict_d = 1'b1;
          if (busy_cnt_q <= CNT_ONE) begin
            busy_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            busy_cnt_d = busy_cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    stall_c = d_user && ((state_q == RUN) || e_start || bus.md_busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_cnt_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.md_start = md_start_c;
  assign bus.md_kind  = md_kind_c;
  assign bus.stall_D  = stall_c;
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Scoreboard bench for md_hazard_ctrl: each cycle's expected outputs are queued
// as the stimulus is driven and popped when the outputs are sampled.
module tb_md_hazard_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0109_0018;
  localparam logic [31:0] MULTU = 32'h0109_0019;
  localparam logic [31:0] DIV   = 32'h0109_001A;
  localparam logic [31:0] DIVU  = 32'h0109_001B;
  localparam logic [31:0] MSUB  = 32'h7109_0004;
  localparam logic [31:0] MTHI  = 32'h0100_0011;
  localparam logic [31:0] MTLO  = 32'h0100_0013;
  localparam logic [31:0] MFLO  = 32'h0000_5012;
  localparam logic [31:0] MFHI  = 32'h0000_4010;
  localparam logic [31:0] ADD   = 32'h012A_0020;

  typedef struct packed {
    logic       st;
    logic [1:0] k;
    logic       sd;
    logic [3:0] c;
    logic       cf;
  } exp_t;

  typedef struct packed {
    logic        r;
    logic        b;
    logic [31:0] d;
    logic [31:0] e;
    exp_t        x;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  md_hazard_if #(.CNT_W(4)) bus();

  md_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(5), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic r, input logic b, input logic [31:0] d,
                               input logic [31:0] e, input logic st, input logic [1:0] k,
                               input logic sd, input logic [3:0] c, input logic cf);
    stim_t s;
    s.r = r; s.b = b; s.d = d; s.e = e;
    s.x = '{st: st, k: k, sd: sd, c: c, cf: cf};
    return s;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g = '{st: bus.md_start, k: bus.md_kind, sd: bus.stall_D, c: bus.busy_cnt, cf: bus.conflict};
    return g;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.r;
    bus.md_busy = s.b;
    bus.IR_D = s.d;
    bus.IR_E = s.e;
    sb.push_back(s.x);
  endtask

  task automatic test_reset();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(1, 0, NOP, NOP, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_mult();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(0, 0, MFLO, MULT, 1, 0, 1, 0, 0));
    for (int n = 4; n >= 1; n--) v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 1, 4'(n), 0));
    v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mult[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_div();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(0, 0, MTHI, DIV, 1, 1, 1, 0, 0));
    for (int n = 4; n >= 1; n--) v.push_back(mk(0, 0, MTHI, NOP, 0, 3, 1, 4'(n), 0));
    v.push_back(mk(0, 0, MTHI, NOP, 0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL div[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_md_busy();
    stim_t v[$];
    exp_t got, want;
    for (int n = 0; n < 3; n++) v.push_back(mk(0, 1, MFHI, NOP, 0, 3, 1, 0, 0));
    v.push_back(mk(0, 0, MFHI, NOP, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 1, ADD, NOP, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL md_busy[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_conflict();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(0, 0, NOP, MULT, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, NOP,  0, 3, 0, 4, 0));
    v.push_back(mk(0, 0, NOP, NOP,  0, 3, 0, 3, 0));
    v.push_back(mk(0, 0, NOP, DIVU, 1, 1, 0, 2, 0));
    for (int n = 4; n >= 1; n--) v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 4'(n), 1));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 1));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL conflict[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_nonmd_rst();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(0, 0, ADD, MULT, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, ADD, NOP,  0, 3, 0, 4, 1));
    v.push_back(mk(0, 0, ADD, NOP,  0, 3, 0, 3, 1));
    v.push_back(mk(1, 0, ADD, NOP,  0, 3, 0, 2, 1));
    v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 0, ADD, NOP,  0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL nonmd_rst[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_write_conflict();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(0, 0, NOP, MTLO, 0, 3, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, MSUB, 1, 2, 0, 0, 0));
    v.push_back(mk(0, 0, NOP, MTHI, 0, 3, 0, 4, 0));
    for (int n = 3; n >= 1; n--) v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 4'(n), 1));
    v.push_back(mk(0, 0, NOP, NOP, 0, 3, 0, 0, 1));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL write_conflict[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    exp_t got, want;
    v.push_back(mk(1, 0, NOP, NOP, 0, 3, 0, 0, 1));
    v.push_back(mk(0, 0, MFLO, MULTU, 1, 0, 1, 0, 0));
    for (int n = 4; n >= 1; n--) v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 1, 4'(n), 0));
    v.push_back(mk(0, 0, MFLO, DIV, 1, 1, 1, 0, 0));
    for (int n = 4; n >= 1; n--) v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 1, 4'(n), 0));
    v.push_back(mk(0, 0, MFLO, NOP, 0, 3, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d] got st=%b k=%0d sd=%b c=%0d cf=%b want st=%b k=%0d sd=%b c=%0d cf=%b",
                 i, got.st, got.k, got.sd, got.c, got.cf, want.st, want.k, want.sd, want.c, want.cf);
      end
    end
  endtask

  initial begin
    bus.IR_D = NOP;
    bus.IR_E = NOP;
    bus.md_busy = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_md_busy();
    test_conflict();
    test_nonmd_rst();
    test_write_conflict();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_hazard_ctrl.md
Name: md_hazard_ctrl

Overview:
- Issue and interlock controller for the multiply/divide unit.
- Sits between decode (D) and execute (E).
- Decodes the E-stage instruction to issue multiply/divide/msub operations, and tracks the in-flight operation with its own latency counter.
- Stalls any D-stage instruction that touches HI/LO until the unit has written back. Also reports issue conflicts.

Parameters:
- MULT_LAT, 5, cycles from issue until HI/LO valid for mult/multu/msub (minimum 2).
- DIV_LAT, 5, cycles from issue until HI/LO valid for div/divu (minimum 2).
- CNT_W, 4, width of the latency counter; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- IR_D  in  32  instruction in decode stage.
- IR_E  in  32  instruction in execute stage; a bubble is 32'h0.
- md_busy  in  1  Busy from the multiply/divide unit.
- md_start  out  1  combinational pulse: E-stage md op issued this cycle.
- md_kind  out  2  issued op class: 0 mult/multu, 1 div/divu, 2 msub, 3 none.
- stall_D  out  1  combinational: hold D, inject bubble into E.
- busy_cnt  out  CNT_W  remaining cycles of the in-flight op (0 when idle).
- conflict  out  1  sticky: op issued while another was in flight.

Behaviour:
- Decode, all with opcode 6'b000000 unless stated:
  - Start ops: multu funct 011001, mult 011000, divu 011011, div 011010; msub opcode 011100 funct 000100.
  - Write ops: mthi 010001, mtlo 010011.
  - Read ops: mfhi 010000, mflo 010010.
  - HI/LO user in D = any start, write or read op.
- FSM states: IDLE, RUN.
- Reset: state=IDLE, busy_cnt=0, conflict=0. Combinational outputs then follow their equations.
- IDLE:
  - If IR_E is a start op: md_start=1, md_kind set to the op class.
  - busy_cnt loads LAT-1 (MULT_LAT for mult/multu/msub, DIV_LAT for div/divu).
  - Next state is RUN.
- RUN:
  - busy_cnt decrements each cycle.
  - When busy_cnt==1 at the clock edge: next busy_cnt=0, state goes to IDLE.
  - HI/LO is readable in the first IDLE cycle after RUN.
- Conflict: start op in E while in RUN:
  - md_start=1 and conflict is set (sticky until rst).
  - Counter reloads with the new op's LAT-1; state stays RUN. Latest issue wins.
- mthi/mtlo in E: never starts the FSM, md_start=0.
  - mthi/mtlo in E while RUN: treated as a conflict (set conflict), counter unchanged.
- stall_D = D is a HI/LO user AND (state==RUN OR IR_E is a start op OR md_busy).
  - md_busy is ORed in so that a slower unit is also honoured.
- md_kind=3 whenever md_start=0.
- Non-md instructions never stall and never change state.
- rst asserted mid-RUN: next cycle is IDLE, busy_cnt=0, conflict=0, stall_D drops unless md_busy is still high.
- Simultaneous events:
  - Start op in E and read op in D: stall_D=1 in that same cycle.
  - busy_cnt reaching 0 and a start op in E in the same cycle: reload. State is IDLE in that cycle, so no conflict is raised.
- Arithmetic: busy_cnt unsigned, never wraps below 0; an IDLE decrement is inhibited.

Test Plan:
- Reset release, IR_E=0, IR_D=0, md_busy=0 -> busy_cnt=0, stall_D=0, md_start=0, md_kind=3, conflict=0.
- IR_E=0x01090018 (mult) for one cycle, then 0; IR_D=0x00005012 (mflo) throughout; MULT_LAT=5 -> md_start=1 and md_kind=0 on cycle 0. busy_cnt reads 4,3,2,1 on cycles 1-4. stall_D=1 on cycles 0-4 and 0 on cycle 5.
- IR_E=0x0109001A (div), DIV_LAT=5, IR_D=0x01000011 (mthi) -> md_kind=1, mthi stalled 5 cycles, released when busy_cnt=0.
- Issue mult, then in the 3rd RUN cycle force IR_E=0x0109001B (divu) -> conflict=1 and stays 1, busy_cnt reloads to 4.
- IR_E=0x01090018, IR_D=0x012A0020 (add) -> stall_D=0 every cycle. Also rst pulsed at busy_cnt=2 -> next cycle busy_cnt=0, state IDLE.
- Idle, md_busy forced 1, IR_D=0x00004010 (mfhi) -> stall_D=1 while md_busy=1, busy_cnt stays 0.
